// File: rtl/xtdot_pkg.sv
// Shared types and constants for the sequential X-transpose-times-force engine.
// XTDOT_OUT_BUF_EN (optional) enables the decoupled output buffer and HOLD state.
package xtdot_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_e;

  localparam int NUM_STEPS = 5;
  localparam int STEP_W    = 3;
  localparam int NUM_LANES = 6;
  localparam int NUM_X     = 23;

  // Terms per output lane {AX,AY,AZ,LX,LY,LZ} = {5,5,5,2,3,3}; element 0 is lane AX
  localparam logic [NUM_LANES-1:0][STEP_W-1:0] TERM_CNT =
    {3'd3, 3'd3, 3'd2, 3'd5, 3'd5, 3'd5};

  // Force-vector component order
  localparam int F_AX = 0, F_AY = 1, F_AZ = 2, F_LX = 3, F_LY = 4, F_LZ = 5;

  // Slots of the 23 nonzero X entries inside the captured operand array
  localparam int X_AX_AX = 0,  X_AX_AY = 1,  X_AX_AZ = 2;
  localparam int X_AY_AX = 3,  X_AY_AY = 4,  X_AY_AZ = 5;
  localparam int X_AZ_AY = 6,  X_AZ_AZ = 7;
  localparam int X_LX_AX = 8,  X_LX_AY = 9,  X_LX_AZ = 10, X_LX_LX = 11, X_LX_LY = 12, X_LX_LZ = 13;
  localparam int X_LY_AX = 14, X_LY_AY = 15, X_LY_AZ = 16, X_LY_LX = 17, X_LY_LY = 18, X_LY_LZ = 19;
  localparam int X_LZ_AX = 20, X_LZ_LY = 21, X_LZ_LZ = 22;

endpackage

// File: rtl/xtdot_lane.sv
// One fixed-point multiply-accumulate lane; the step index selects the operand pair.
// With XTDOT_OUT_BUF_EN the lane exports its next-state sum so the result can be buffered on the last step.
module xtdot_lane
  import xtdot_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [STEP_W-1:0]                  sel,
  input  logic                               acc_en,
  input  logic                               clr,
  input  logic [NUM_STEPS-1:0][WIDTH-1:0]    x_terms,
  input  logic [NUM_STEPS-1:0][WIDTH-1:0]    f_terms,
  output logic [WIDTH-1:0]                   acc
);

  logic [WIDTH-1:0]          a, b, prod, acc_d, acc_q;
  logic signed [2*WIDTH-1:0] full;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a = '0;
    b = '0;
    if (sel < STEP_W'(NUM_STEPS)) begin
      a = x_terms[sel];
      b = f_terms[sel];
    end
    full = signed'({{WIDTH{a[WIDTH-1]}}, a}) * signed'({{WIDTH{b[WIDTH-1]}}, b});
    prod = WIDTH'(full >>> DECIMAL_BITS);
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + prod;
    else             acc_d = acc_q;
  end

  // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`ifdef XTDOT_OUT_BUF_EN
  assign acc = acc_d;
`else
  assign acc = acc_q;
`endif

endmodule

// File: rtl/xtdot_seq.sv
// Sequential X^T * f engine: 6 MAC lanes over 5 steps with valid/ready on both sides.
// Define XTDOT_OUT_BUF_EN to add an output buffer that lets a new computation overlap a stalled consumer.
module xtdot_seq
  import xtdot_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xform_in_AX_AX, xform_in_AX_AY, xform_in_AX_AZ,
  input  logic [WIDTH-1:0] xform_in_AY_AX, xform_in_AY_AY, xform_in_AY_AZ,
  input  logic [WIDTH-1:0] xform_in_AZ_AY, xform_in_AZ_AZ,
  input  logic [WIDTH-1:0] xform_in_LX_AX, xform_in_LX_AY, xform_in_LX_AZ,
  input  logic [WIDTH-1:0] xform_in_LX_LX, xform_in_LX_LY, xform_in_LX_LZ,
  input  logic [WIDTH-1:0] xform_in_LY_AX, xform_in_LY_AY, xform_in_LY_AZ,
  input  logic [WIDTH-1:0] xform_in_LY_LX, xform_in_LY_LY, xform_in_LY_LZ,
  input  logic [WIDTH-1:0] xform_in_LZ_AX, xform_in_LZ_LY, xform_in_LZ_LZ,
  input  logic [WIDTH-1:0] vec_in_AX, vec_in_AY, vec_in_AZ,
  input  logic [WIDTH-1:0] vec_in_LX, vec_in_LY, vec_in_LZ,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] xtvec_out_AX, xtvec_out_AY, xtvec_out_AZ,
  output logic [WIDTH-1:0] xtvec_out_LX, xtvec_out_LY, xtvec_out_LZ
);

  logic [WIDTH-1:0] x_in [NUM_X],     x_d [NUM_X],     x_q [NUM_X];
  logic [WIDTH-1:0] f_in [NUM_LANES], f_d [NUM_LANES], f_q [NUM_LANES];
  logic [WIDTH-1:0] acc [NUM_LANES], res [NUM_LANES];
  logic [NUM_STEPS-1:0][WIDTH-1:0] lane_x [NUM_LANES], lane_f [NUM_LANES];
  logic [NUM_LANES-1:0] acc_en;
  state_e             state_d, state_q;
  logic [STEP_W-1:0]  step_d, step_q;
  logic               in_ready_q, clr;

  assign x_in = '{xform_in_AX_AX, xform_in_AX_AY, xform_in_AX_AZ,
                  xform_in_AY_AX, xform_in_AY_AY, xform_in_AY_AZ,
                  xform_in_AZ_AY, xform_in_AZ_AZ,
                  xform_in_LX_AX, xform_in_LX_AY, xform_in_LX_AZ,
                  xform_in_LX_LX, xform_in_LX_LY, xform_in_LX_LZ,
                  xform_in_LY_AX, xform_in_LY_AY, xform_in_LY_AZ,
                  xform_in_LY_LX, xform_in_LY_LY, xform_in_LY_LZ,
                  xform_in_LZ_AX, xform_in_LZ_LY, xform_in_LZ_LZ};
  assign f_in = '{vec_in_AX, vec_in_AY, vec_in_AZ, vec_in_LX, vec_in_LY, vec_in_LZ};

  // Column j of X paired with the force component of each contributing row; step 0 is rightmost
  assign lane_x[0] = {x_q[X_LZ_AX], x_q[X_LY_AX], x_q[X_LX_AX], x_q[X_AY_AX], x_q[X_AX_AX]};
  assign lane_x[1] = {x_q[X_LY_AY], x_q[X_LX_AY], x_q[X_AZ_AY], x_q[X_AY_AY], x_q[X_AX_AY]};
  assign lane_x[2] = {x_q[X_LY_AZ], x_q[X_LX_AZ], x_q[X_AZ_AZ], x_q[X_AY_AZ], x_q[X_AX_AZ]};
  assign lane_x[3] = {{(3*WIDTH){1'b0}}, x_q[X_LY_LX], x_q[X_LX_LX]};
  assign lane_x[4] = {{(2*WIDTH){1'b0}}, x_q[X_LZ_LY], x_q[X_LY_LY], x_q[X_LX_LY]};
  assign lane_x[5] = {{(2*WIDTH){1'b0}}, x_q[X_LZ_LZ], x_q[X_LY_LZ], x_q[X_LX_LZ]};
  assign lane_f[0] = {f_q[F_LZ], f_q[F_LY], f_q[F_LX], f_q[F_AY], f_q[F_AX]};
  assign lane_f[1] = {f_q[F_LY], f_q[F_LX], f_q[F_AZ], f_q[F_AY], f_q[F_AX]};
  assign lane_f[2] = {f_q[F_LY], f_q[F_LX], f_q[F_AZ], f_q[F_AY], f_q[F_AX]};
  assign lane_f[3] = {{(3*WIDTH){1'b0}}, f_q[F_LY], f_q[F_LX]};
  assign lane_f[4] = {{(2*WIDTH){1'b0}}, f_q[F_LZ], f_q[F_LY], f_q[F_LX]};
  assign lane_f[5] = {{(2*WIDTH){1'b0}}, f_q[F_LZ], f_q[F_LY], f_q[F_LX]};

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign acc_en[j] = (state_q == CALC) && (step_q < TERM_CNT[j]);
    xtdot_lane #(.WIDTH(WIDTH), .DECIMAL_BITS(DECIMAL_BITS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .sel     (step_q),
      .acc_en  (acc_en[j]),
      .clr     (clr),
      .x_terms (lane_x[j]),
      .f_terms (lane_f[j]),
      .acc     (acc[j])
    );
  end

`ifdef XTDOT_OUT_BUF_EN
  logic [WIDTH-1:0] obuf_d [NUM_LANES], obuf_q [NUM_LANES];
  logic             obuf_valid_d, obuf_valid_q, load_obuf, obuf_free;
  assign obuf_free = !obuf_valid_q || out_ready;
`else
  logic out_valid_q;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    f_d     = f_q;
    clr     = 1'b0;
`ifdef XTDOT_OUT_BUF_EN
    load_obuf = 1'b0;
`endif
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        state_d = CALC;
        step_d  = '0;
        clr     = 1'b1;
        x_d     = x_in;
        f_d     = f_in;
      end
      CALC: if (step_q == STEP_W'(NUM_STEPS - 1)) begin
        step_d = '0;
`ifdef XTDOT_OUT_BUF_EN
        // The lanes present the completed sum this cycle, so it can go straight to the buffer
        if (obuf_free) begin
          load_obuf = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = HOLD;
        end
`else
        state_d = DONE;
`endif
      end else begin
        step_d = step_q + STEP_W'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      HOLD: begin
`ifdef XTDOT_OUT_BUF_EN
        if (obuf_free) begin
          load_obuf = 1'b1;
          state_d   = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      in_ready_q <= 1'b1;
      // NOTE: operand registers are reset as well so the datapath never holds X, even though accept reloads them.
      for (int i = 0; i < NUM_X; i++)     x_q[i] <= '0;
      for (int i = 0; i < NUM_LANES; i++) f_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      in_ready_q <= (state_d == IDLE);
      x_q        <= x_d;
      f_q        <= f_d;
    end
  end

`ifdef XTDOT_OUT_BUF_EN
  always_comb begin
    obuf_d       = obuf_q;
    obuf_valid_d = obuf_valid_q;
    if (obuf_valid_q && out_ready) obuf_valid_d = 1'b0;
    if (load_obuf) begin
      obuf_d       = acc;
      obuf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf_valid_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) obuf_q[i] <= '0;
    end else begin
      obuf_valid_q <= obuf_valid_d;
      obuf_q       <= obuf_d;
    end
  end

  assign out_valid = obuf_valid_q;
  assign res       = obuf_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid_q <= 1'b0;
    else       out_valid_q <= (state_d == DONE);
  end

  assign out_valid = out_valid_q;
  assign res       = acc;
`endif

  assign in_ready     = in_ready_q;
  assign xtvec_out_AX = res[0];
  assign xtvec_out_AY = res[1];
  assign xtvec_out_AZ = res[2];
  assign xtvec_out_LX = res[3];
  assign xtvec_out_LY = res[4];
  assign xtvec_out_LZ = res[5];

endmodule

// File: tb/tb_xtdot_seq.sv
// Self-checking bench for xtdot_seq: directed cases plus randomized handshakes vs. a matrix-level model.
// Honours XTDOT_OUT_BUF_EN for the backpressure scenario.
module tb_xtdot_seq;

  localparam int W = 32;
  typedef logic [5:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] m [6][6];
  logic [W-1:0] f [6];
  logic [W-1:0] o [6];
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb [$];

  always #5 clk = ~clk;

  xtdot_seq #(.WIDTH(W), .DECIMAL_BITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .xform_in_AX_AX(m[0][0]), .xform_in_AX_AY(m[0][1]), .xform_in_AX_AZ(m[0][2]),
    .xform_in_AY_AX(m[1][0]), .xform_in_AY_AY(m[1][1]), .xform_in_AY_AZ(m[1][2]),
    .xform_in_AZ_AY(m[2][1]), .xform_in_AZ_AZ(m[2][2]),
    .xform_in_LX_AX(m[3][0]), .xform_in_LX_AY(m[3][1]), .xform_in_LX_AZ(m[3][2]),
    .xform_in_LX_LX(m[3][3]), .xform_in_LX_LY(m[3][4]), .xform_in_LX_LZ(m[3][5]),
    .xform_in_LY_AX(m[4][0]), .xform_in_LY_AY(m[4][1]), .xform_in_LY_AZ(m[4][2]),
    .xform_in_LY_LX(m[4][3]), .xform_in_LY_LY(m[4][4]), .xform_in_LY_LZ(m[4][5]),
    .xform_in_LZ_AX(m[5][0]), .xform_in_LZ_LY(m[5][4]), .xform_in_LZ_LZ(m[5][5]),
    .vec_in_AX(f[0]), .vec_in_AY(f[1]), .vec_in_AZ(f[2]),
    .vec_in_LX(f[3]), .vec_in_LY(f[4]), .vec_in_LZ(f[5]),
    .out_valid(out_valid), .out_ready(out_ready),
    .xtvec_out_AX(o[0]), .xtvec_out_AY(o[1]), .xtvec_out_AZ(o[2]),
    .xtvec_out_LX(o[3]), .xtvec_out_LY(o[4]), .xtvec_out_LZ(o[5])
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mulfx(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    p = p >>> 16;
    return p[W-1:0];
  endfunction

  // out[j] = sum_i X[i][j] * f[i], entries outside the pattern are zero
  function automatic vec_t model(input logic [W-1:0] mm [6][6], input logic [W-1:0] ff [6]);
    vec_t r = '0;
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 6; i++)
        r[j] = r[j] + mulfx(mm[i][j], ff[i]);
    return r;
  endfunction

  function automatic bit in_pattern(input int i, input int j);
    case (i)
      0, 1:    return j <= 2;
      2:       return (j == 1) || (j == 2);
      3, 4:    return 1'b1;
      default: return (j == 0) || (j == 4) || (j == 5);
    endcase
  endfunction

  task automatic clear_operands();
    for (int i = 0; i < 6; i++) begin
      f[i] = '0;
      for (int j = 0; j < 6; j++) m[i][j] = '0;
    end
  endtask

  task automatic rand_operands();
    for (int i = 0; i < 6; i++) begin
      f[i] = $urandom;
      for (int j = 0; j < 6; j++) m[i][j] = in_pattern(i, j) ? $urandom : '0;
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t exp);
    for (int j = 0; j < 6; j++) check($sformatf("%s_out%0d", tag, j), o[j], exp[j]);
  endtask

  // Waits (bounded) for in_ready, then lets the next edge accept the current operands
  task automatic accept(input string tag);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_accept_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, 5);
  endtask

  task automatic run_directed(input string tag, input vec_t exp);
    out_ready = 1'b1;
    accept(tag);
    wait_result(tag);
    check_outputs(tag, exp);
    @(posedge clk); #1;
    check({tag, "_drained"}, out_valid, 0);
    check({tag, "_ready_again"}, in_ready, 1);
  endtask

  task automatic identity_case(input string tag);
    vec_t e;
    clear_operands();
    for (int i = 0; i < 6; i++) begin
      m[i][i] = 32'h0001_0000;
      f[i]    = W'(i + 1) << 16;
      e[i]    = f[i];
    end
    run_directed(tag, e);
  endtask

  initial begin
    vec_t e, e2;
    int   sent, recv;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_operands();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check_outputs("rst", '0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_rel_in_ready", in_ready, 1);

    identity_case("ident");

    clear_operands();
    m[4][0] = 32'h0002_0000;
    f[4]    = 32'h0003_0000;
    e       = '0;
    e[0]    = 32'h0006_0000;
    run_directed("transpose", e);

    clear_operands();
    m[3][3] = 32'hFFFF_0000;
    f[3]    = 32'h0000_8000;
    e       = '0;
    e[3]    = 32'hFFFF_8000;
    run_directed("neg_frac", e);

    // Backpressure: consumer stalls for 10 cycles
    rand_operands();
    e = model(m, f);
    out_ready = 1'b0;
    accept("bp");
    rand_operands();
    wait_result("bp");
`ifdef XTDOT_OUT_BUF_EN
    e2 = model(m, f);
    in_valid = 1'b1;
    check("bp_second_ready", in_ready, 1);
    @(posedge clk); #1;
    rand_operands();
`else
    e2 = '0;
    in_valid = 1'b1;
`endif
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", c), out_valid, 1);
      check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
      check_outputs($sformatf("bp_c%0d", c), e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
`ifdef XTDOT_OUT_BUF_EN
    check("bp_second_valid", out_valid, 1);
    check_outputs("bp_second", e2);
    @(posedge clk); #1;
`endif
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_no_third", out_valid, 0);

    // Reset during CALC step 2
    rand_operands();
    out_ready = 1'b1;
    accept("mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check_outputs("mid_rst", '0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_out_valid", out_valid, 0);
    check_outputs("mid_rel", '0);
    identity_case("post_reset");

    // Randomized traffic with random valid/ready against the scoreboard
    sent = 0;
    recv = 0;
    sb.delete();
    for (int cyc = 0; cyc < 20000 && recv < 200; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_operands();
      if (in_valid && in_ready) begin
        sb.push_back(model(m, f));
        sent++;
      end
      if (out_valid && out_ready) begin
        check("rand_expected_result", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_outputs($sformatf("rand%0d", recv), e);
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    check("rand_received", recv, 200);
    check("rand_sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
